// File: rtl/output_port_arbiter.sv
// Wormhole output-port scheduler: round-robin grant held per packet,
// credit-throttled pops from the owner FIFO onto a registered link.
module output_port_arbiter #(
    parameter int NUM_PORTS  = 5,
    parameter int FLIT_WIDTH = 17,
    parameter int CREDITS    = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS*FLIT_WIDTH-1:0] flits_i,
    output logic [NUM_PORTS-1:0]            send_o,
    input  logic                            credit_i,
    output logic [FLIT_WIDTH-1:0]           data_o,
    output logic                            valid_o,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic                            credit_err_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [2:0] CRED_MAX  = 3'(CREDITS);
    localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);
    localparam logic [3:0] NP        = 4'(NUM_PORTS);

    state_t                state_q, state_d;
    logic [2:0]            owner_q, owner_d;
    logic [2:0]            rr_ptr_q, rr_ptr_d;
    logic [2:0]            credits_q, credits_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [FLIT_WIDTH-1:0] flit;
    logic                  fire;
    logic                  found;
    logic [2:0]            pick;
    logic [3:0]            idx;

    assign flit = flits_i[owner_q*FLIT_WIDTH +: FLIT_WIDTH];
    assign fire = (state_q == LOCKED) && req_i[owner_q]
                  && (credits_q != 3'd0);

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_ptr_q} + 4'(i);
            if (idx >= NP) begin
                idx = idx - NP;
            end
            if (!found && req_i[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    // Next state, link capture, pointer update and combinational strobes.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        valid_d  = fire;
        send_o   = '0;
        grant_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                grant_o[owner_q] = 1'b1;
                send_o[owner_q]  = fire;
                if (fire) begin
                    data_d = flit;
                    if (flit[FLIT_WIDTH-1]) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == LAST_PORT) ? 3'd0
                                                          : owner_q + 3'd1;
                    end
                end
            end
        endcase
    end

    // Credit mirror of the downstream FIFO; overflow return is sticky.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({fire, credit_i})
            2'b10: credits_d = credits_q - 3'd1;
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + 3'd1;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            credits_q <= CRED_MAX;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: modelled input FIFOs, link-flit
// scoreboard, directed cycle checks of grant/send/valid/credit error.
module tb_output_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_i;
    logic [84:0] flits_i;
    logic [4:0]  send_o;
    logic        credit_i;
    logic [16:0] data_o;
    logic        valid_o;
    logic [4:0]  grant_o;
    logic        credit_err_o;

    always #5 clk = ~clk;

    output_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .flits_i      (flits_i),
        .send_o       (send_o),
        .credit_i     (credit_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .grant_o      (grant_o),
        .credit_err_o (credit_err_o)
    );

    logic [16:0] mem [5][32];
    int          hd [5];
    int          tl [5];
    logic [4:0]  en;
    logic        auto_cr;
    logic [16:0] exp_q [$];
    logic [16:0] e;
    logic [4:0]  g;
    int          vectors = 0;
    int          miscompares = 0;
    int          nvalid = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < 5; p++) begin
            req_i[p] = en[p] && (hd[p] != tl[p]);
            flits_i[p*17 +: 17] = mem[p][hd[p]];
        end
    endtask

    task automatic load(int p, logic tail, logic [15:0] v, logic ex);
        mem[p][tl[p]] = {tail, v};
        tl[p]++;
        if (ex) exp_q.push_back({tail, v});
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Ends the current cycle; FIFOs pop on the strobes seen this cycle.
    task automatic next();
        logic [4:0] s;
        s = send_o;
        @(posedge clk);
        #1;
        for (int p = 0; p < 5; p++) begin
            if (s[p]) hd[p]++;
        end
        if (auto_cr) credit_i = valid_o;
        refresh();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        credit_i = 1'b0;
        auto_cr  = 1'b0;
        en       = 5'h1f;
        for (int p = 0; p < 5; p++) begin
            hd[p] = 0;
            tl[p] = 0;
            for (int i = 0; i < 32; i++) mem[p][i] = '0;
        end
        refresh();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        nvalid = 0;
    endtask

    // Link monitor: every presented flit must be the next expected one.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            nvalid++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL link_flit: got %0h expected none", data_o);
            end else begin
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    miscompares++;
                    $display("FAIL link_flit: got %0h expected %0h",
                             data_o, e);
                end
            end
        end
    end

    initial begin
        do_reset();
        settle();
        chk("rst_grant", grant_o, 0);
        chk("rst_send", send_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_err", credit_err_o, 0);

        // three-flit packet on port 2
        auto_cr = 1'b1;
        next();
        load(2, 1'b0, 16'h2001, 1'b1);
        load(2, 1'b0, 16'h2002, 1'b1);
        load(2, 1'b1, 16'h2003, 1'b1);
        refresh();
        settle();
        chk("t1_grant_c0", grant_o, 0);
        chk("t1_send_c0", send_o, 0);
        next(); settle();
        chk("t1_grant_c1", grant_o, 5'b00100);
        chk("t1_send_c1", send_o, 5'b00100);
        chk("t1_valid_c1", valid_o, 0);
        next(); settle();
        chk("t1_send_c2", send_o, 5'b00100);
        chk("t1_valid_c2", valid_o, 1);
        next(); settle();
        chk("t1_send_c3", send_o, 5'b00100);
        next(); settle();
        chk("t1_grant_c4", grant_o, 0);
        chk("t1_send_c4", send_o, 0);
        chk("t1_valid_c4", valid_o, 1);
        next(); settle();
        chk("t1_valid_c5", valid_o, 0);
        next();

        // rr_ptr is 3: port 3 beats port 0, then wraps to 0
        load(3, 1'b1, 16'h3001, 1'b1);
        load(0, 1'b1, 16'h0001, 1'b1);
        refresh();
        settle(); next(); settle();
        chk("rr_grant_c1", grant_o, 5'b01000);
        next(); settle();
        chk("rr_grant_c2", grant_o, 0);
        next(); settle();
        chk("rr_grant_c3", grant_o, 5'b00001);
        next(); settle();
        chk("rr_grant_c4", grant_o, 0);
        next();

        // all five ports with single-flit packets
        do_reset();
        auto_cr = 1'b1;
        for (int p = 0; p < 5; p++) load(p, 1'b1, 16'h4000 + 16'(p), 1'b1);
        for (int p = 0; p < 5; p++) load(p, 1'b1, 16'h4100 + 16'(p), 1'b1);
        refresh();
        settle();
        for (int k = 1; k <= 20; k++) begin
            next(); settle();
            g = (k % 2 == 1) ? 5'(1 << (((k - 1) / 2) % 5)) : 5'b0;
            chk("t2_grant", grant_o, g);
        end
        next(); next();

        // no credit return: 7-flit packet on port 1
        do_reset();
        for (int i = 0; i < 7; i++)
            load(1, 1'(i == 6), 16'h5000 + 16'(i), 1'(i < 6));
        refresh();
        settle(); next();
        for (int c = 1; c <= 5; c++) begin
            settle();
            chk("t3_send_live", send_o, 5'b00010);
            next();
        end
        settle();
        chk("t3_send_c6", send_o, 0);
        chk("t3_grant_c6", grant_o, 5'b00010);
        next(); settle();
        chk("t3_valid_c7", valid_o, 0);
        chk("t3_send_c7", send_o, 0);
        next();
        credit_i = 1'b1;
        settle();
        chk("t3_send_credit_cycle", send_o, 0);
        next();
        credit_i = 1'b0;
        settle();
        chk("t3_send_after_credit", send_o, 5'b00010);
        next(); settle();
        chk("t3_valid_c10", valid_o, 1);
        chk("t3_send_c10", send_o, 0);
        next(); settle();
        chk("t3_valid_c11", valid_o, 0);
        chk("t3_flit_count", nvalid, 6);

        // fire and credit together hold the counter at 2
        do_reset();
        for (int i = 0; i < 16; i++)
            load(4, 1'(i == 15), 16'h6000 + 16'(i), 1'(i < 15));
        refresh();
        settle(); next();
        for (int c = 1; c <= 3; c++) begin
            settle();
            chk("t4_send_pre", send_o, 5'b10000);
            next();
        end
        credit_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("t4_send_both", send_o, 5'b10000);
            next();
        end
        credit_i = 1'b0;
        settle();
        chk("t4_send_c14", send_o, 5'b10000);
        next(); settle();
        chk("t4_send_c15", send_o, 5'b10000);
        next(); settle();
        chk("t4_send_c16", send_o, 0);
        chk("t4_grant_c16", grant_o, 5'b10000);
        next(); settle();
        chk("t4_valid_c17", valid_o, 0);
        chk("t4_flit_count", nvalid, 15);

        // owner FIFO runs dry mid-packet while port 0 waits
        do_reset();
        auto_cr = 1'b1;
        for (int i = 0; i < 4; i++)
            load(3, 1'(i == 3), 16'h7000 + 16'(i), 1'b1);
        refresh();
        settle();
        chk("t5_grant_c0", grant_o, 0);
        next(); settle();
        chk("t5_grant_c1", grant_o, 5'b01000);
        chk("t5_send_c1", send_o, 5'b01000);
        next(); settle();
        chk("t5_send_c2", send_o, 5'b01000);
        next();
        en[3] = 1'b0;
        load(0, 1'b1, 16'h7100, 1'b0);
        refresh();
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t5_grant_stall", grant_o, 5'b01000);
            chk("t5_send_stall", send_o, 0);
            next();
        end
        en[3] = 1'b1;
        refresh();
        exp_q.push_back({1'b1, 16'h7100});
        settle();
        chk("t5_send_c7", send_o, 5'b01000);
        next(); settle();
        chk("t5_send_c8", send_o, 5'b01000);
        next(); settle();
        chk("t5_grant_c9", grant_o, 0);
        next(); settle();
        chk("t5_grant_c10", grant_o, 5'b00001);
        next(); next(); next();

        // reset mid-packet at credits = 1
        do_reset();
        for (int i = 0; i < 8; i++)
            load(2, 1'(i == 7), 16'h8000 + 16'(i), 1'(i < 4));
        refresh();
        settle(); next();
        for (int c = 1; c <= 4; c++) begin
            settle(); next();
        end
        rst = 1'b1;
        for (int p = 0; p < 5; p++) hd[p] = tl[p];
        refresh();
        settle(); next();
        rst = 1'b0;
        settle();
        chk("t6_grant", grant_o, 0);
        chk("t6_send", send_o, 0);
        chk("t6_valid", valid_o, 0);
        chk("t6_err_clear", credit_err_o, 0);
        next();
        credit_i = 1'b1;
        settle(); next();
        credit_i = 1'b0;
        settle();
        chk("t6_err_set", credit_err_o, 1);
        next();
        auto_cr = 1'b1;
        load(0, 1'b1, 16'h8100, 1'b1);
        refresh();
        settle(); next(); settle(); next(); settle(); next(); settle();
        chk("t6_err_sticky", credit_err_o, 1);
        do_reset();
        settle();
        chk("t6_err_after_rst", credit_err_o, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Wormhole output-port scheduler for one router output link. Five input-port buffer_storage FIFOs (ports 0..4) compete for the link. The block grants one port round-robin and holds that grant for a whole packet. It pops flits from the granted FIFO with single-cycle send pulses and registers them onto the link. Flow is throttled by a credit counter that mirrors free slots in the downstream FIFO.

## Interface
Parameters:
- NUM_PORTS, 5, number of competing input FIFOs (fixed at 5; port index 0..4)
- FLIT_WIDTH, 17, flit width; bit [16] is the tail flag
- CREDITS, 5, downstream FIFO depth and reset value of the credit counter

Ports:
- clk  in  1  clock, all state rising-edge
- rst  in  1  synchronous, active-high reset
- req_i  in  5  bit p high: FIFO p is non-empty and its front flit is routed to this output
- flits_i  in  85  front flits of the FIFOs; port p occupies [17p+16 : 17p]
- send_o  out  5  one-hot pop strobe to the granted FIFO; combinational, at most one bit high
- credit_i  in  1  one downstream slot freed this cycle
- data_o  out  17  registered link flit
- valid_o  out  1  data_o holds a new flit this cycle
- grant_o  out  5  one-hot current owner; all zero in IDLE
- credit_err_o  out  1  sticky; set on a credit return while the counter is already at CREDITS

## Operation
- State IDLE:
  - grant_o = 0 and send_o = 0.
  - If any req_i bit is set, pick the first requester at or after rr_ptr, searching upward with wrap 4→0.
  - Load the grant and move to LOCKED on the next edge.
  - No flit is sent in the arbitration cycle.
- State LOCKED, owner g:
  - fire = req_i[g] & (credits != 0).
  - send_o[g] = fire.
  - On fire, the flit at flits_i[17g+16:17g] is captured into data_o with valid_o = 1 on the next edge.
  - If !fire, valid_o = 0 next cycle and data_o holds its last value.
- Tail handling:
  - If fire and the sent flit has bit16 = 1, next state is IDLE and rr_ptr = (g+1) mod 5.
  - A single-flit packet (head = tail) releases after one send.
- Owner FIFO empty mid-packet (req_i[g] low): the block stays LOCKED. It does not re-arbitrate until the tail flit is sent.
- Credit counter (3 bits, range 0..CREDITS):
  - fire alone: decrement.
  - credit_i alone: increment.
  - Both in the same cycle: unchanged.
  - credit_i at CREDITS without fire: counter stays at CREDITS and credit_err_o is set.
  - The counter never underflows, because fire requires credits != 0.
- Requests from non-owner ports are ignored while LOCKED.

## Timing
- Values on reset:
  - state IDLE
  - rr_ptr = 0
  - credits = CREDITS
  - grant_o = 0
  - send_o = 0
  - valid_o = 0
  - data_o = 0
  - credit_err_o = 0
- rst mid-packet: all of the above at the next edge. The partial packet is abandoned; the FIFO and downstream recovery are not this block's concern.
- Latency, request to first flit on link: req_i rises in cycle t (IDLE), grant in t+1, send_o in t+1, valid_o/data_o in t+2.
- Throughput: with credits available and req held, one flit per cycle. Back-to-back packets from different ports lose one cycle (IDLE arbitration) between the tail and the next head.
- send_o depends combinationally on req_i, the current grant and the credit count. It must be sampled by the FIFO on the same edge that captures data_o.
- A credit returned in cycle t can enable fire in cycle t+1, not in t.

## Test plan
- Reset, then req_i = 5'b00100 with a 3-flit packet (tail flag on flit 3) → grant_o = 5'b00100 at cycle 1; send_o[2] high in cycles 1–3; valid_o high in cycles 2–4 with the matching data_o; IDLE in cycle 4; rr_ptr = 3.
- All five ports requesting single-flit packets continuously, credits refilled every cycle → grants in order 0,1,2,3,4,0; each grant lasts one flit, followed by one IDLE cycle.
- No credit_i, port 1 sending a 7-flit packet → exactly 5 flits are sent, then send_o = 0 and valid_o = 0. One credit_i pulse yields exactly one more flit, in the following cycle.
- Simultaneous fire and credit_i for 10 cycles starting at credits = 2 → counter stays at 2, and 10 flits are sent.
- Port 3 locked, req_i[3] dropped for 4 cycles mid-packet while port 0 requests → grant_o stays 5'b01000 and send_o = 0. Port 3 resumes and finishes its tail before port 0 is granted.
- rst asserted mid-packet with credits = 1 → next cycle: grant_o = 0, credits = 5, valid_o = 0. An extra credit_i pulse then sets credit_err_o = 1, and it stays set until rst.
